// File: rtl/age_ordered_rs.sv
// age_ordered_rs: reservation station for the integer/branch execution path.
// It holds up to RS_SIZE waiting instructions and snoops NUM_CDB external
// result buses plus its own broadcast. Each cycle it issues at most one ready
// entry into a registered result slot. The slot holds its value until the CDB
// arbiter grants it.
//
// Optional feature: RS_AGE_ORDER_EN.
//   - Defined: the oldest ready entry issues first.
//   - Undefined: there are no age registers, and the lowest-index ready entry
//     issues first.
//
// Ports:
//   Sys_clk, Sys_rst (async, active high), Sys_rdy (global enable)
//   DPRS_*          dispatch request: pc, operand values/tags, imm, opcode,
//                   destination RoB index
//   RSDP_full       all entries busy
//   CDBRS_en/_RoB_index/_value   external result buses (packed per channel)
//   CDBRS_grant     arbiter accepts the current result slot
//   RSCDB_*         result slot: valid, RoB index, value, next pc
//   RoBRS_flush     mispredict flush, synchronous
//
// Opcode encoding (1..37) follows RV32I listing order:
//   lui auipc jal jalr beq bne blt bge bltu bgeu
//   lb lh lw lbu lhu sb sh sw
//   addi slti sltiu xori ori andi slli srli srai
//   add sub sll slt sltu xor srl sra or and
module age_ordered_rs #(
   parameter int RS_WIDTH   = 3,
   parameter int RoB_WIDTH  = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_CDB    = 1
) (
   input  logic                      Sys_clk,
   input  logic                      Sys_rst,
   input  logic                      Sys_rdy,
   input  logic                      DPRS_en,
   input  logic [ADDR_WIDTH-1:0]     DPRS_pc,
   input  logic [31:0]               DPRS_Vj,
   input  logic [31:0]               DPRS_Vk,
   input  logic [RoB_WIDTH:0]        DPRS_Qj,
   input  logic [RoB_WIDTH:0]        DPRS_Qk,
   input  logic [31:0]               DPRS_imm,
   input  logic [6:0]                DPRS_opcode,
   input  logic [RoB_WIDTH-1:0]      DPRS_RoB_index,
   output logic                      RSDP_full,
   input  logic [NUM_CDB-1:0]        CDBRS_en,
   input  logic [NUM_CDB*RoB_WIDTH-1:0] CDBRS_RoB_index,
   input  logic [NUM_CDB*32-1:0]     CDBRS_value,
   input  logic                      CDBRS_grant,
   output logic                      RSCDB_en,
   output logic [RoB_WIDTH-1:0]      RSCDB_RoB_index,
   output logic [31:0]               RSCDB_value,
   output logic [ADDR_WIDTH-1:0]     RSCDB_next_pc,
   input  logic                      RoBRS_flush
);

   localparam int RS_SIZE = 1 << RS_WIDTH;
   localparam int TW      = RoB_WIDTH + 1;
   localparam logic [TW-1:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

   typedef enum logic [6:0] {
      OP_LUI  = 7'd1,  OP_AUIPC = 7'd2,  OP_JAL  = 7'd3,  OP_JALR = 7'd4,
      OP_BEQ  = 7'd5,  OP_BNE   = 7'd6,  OP_BLT  = 7'd7,  OP_BGE  = 7'd8,
      OP_BLTU = 7'd9,  OP_BGEU  = 7'd10,
      OP_ADDI = 7'd19, OP_SLTI  = 7'd20, OP_SLTIU = 7'd21, OP_XORI = 7'd22,
      OP_ORI  = 7'd23, OP_ANDI  = 7'd24, OP_SLLI = 7'd25, OP_SRLI = 7'd26,
      OP_SRAI = 7'd27,
      OP_ADD  = 7'd28, OP_SUB   = 7'd29, OP_SLL  = 7'd30, OP_SLT  = 7'd31,
      OP_SLTU = 7'd32, OP_XOR   = 7'd33, OP_SRL  = 7'd34, OP_SRA  = 7'd35,
      OP_OR   = 7'd36, OP_AND   = 7'd37
   } op_e;

   logic [RS_SIZE-1:0]    busy;
   logic [6:0]            op   [RS_SIZE];
   logic [31:0]           vj   [RS_SIZE];
   logic [31:0]           vk   [RS_SIZE];
   logic [TW-1:0]         qj   [RS_SIZE];
   logic [TW-1:0]         qk   [RS_SIZE];
   logic [31:0]           imm  [RS_SIZE];
   logic [ADDR_WIDTH-1:0] pc   [RS_SIZE];
   logic [RoB_WIDTH-1:0]  rob  [RS_SIZE];
`ifdef RS_AGE_ORDER_EN
   logic [RS_WIDTH-1:0]   age     [RS_SIZE];
   logic [RS_WIDTH-1:0]   age_nxt [RS_SIZE];
   logic [RS_WIDTH-1:0]   best_age;
`endif

   logic [RS_SIZE-1:0]    ready;
   logic                  any_ready;
   logic [RS_WIDTH-1:0]   sel;
   logic                  any_free;
   logic [RS_WIDTH-1:0]   alloc;
   logic                  slot_free;
   logic                  do_issue;
   logic                  do_alloc;
   logic                  own_bc;
   logic [31:0]           res_val;
   logic [ADDR_WIDTH-1:0] res_pc;

   assign RSDP_full = &busy;
   assign own_bc    = RSCDB_en && CDBRS_grant;
   assign slot_free = !RSCDB_en || CDBRS_grant;
   assign do_issue  = slot_free && any_ready;
   assign do_alloc  = DPRS_en && !RSDP_full;

   // Returns {tag, value} after snooping all valid broadcasts.
   // The own broadcast wins, then the lowest external channel.
   function automatic logic [TW+31:0] snoop(input logic [TW-1:0] q,
                                            input logic [31:0]   v);
      logic [TW-1:0] rq;
      logic [31:0]   rv;
      logic          hit;
      rq  = q;
      rv  = v;
      hit = 1'b0;
      if (own_bc && q == {1'b0, RSCDB_RoB_index}) begin
         rq  = NON_DEP;
         rv  = RSCDB_value;
         hit = 1'b1;
      end
      for (int unsigned c = 0; c < NUM_CDB; c++) begin
         if (!hit && CDBRS_en[c] &&
             q == {1'b0, CDBRS_RoB_index[c*RoB_WIDTH +: RoB_WIDTH]}) begin
            rq  = NON_DEP;
            rv  = CDBRS_value[c*32 +: 32];
            hit = 1'b1;
         end
      end
      return {rq, rv};
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < RS_SIZE; i++)
         ready[i] = busy[i] && qj[i] == NON_DEP && qk[i] == NON_DEP;
   end

   always_comb begin
      any_ready = 1'b0;
      sel       = '0;
`ifdef RS_AGE_ORDER_EN
      best_age  = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (ready[i] && (!any_ready || age[i] > best_age)) begin
            any_ready = 1'b1;
            sel       = RS_WIDTH'(i);
            best_age  = age[i];
         end
      end
`else
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (ready[i] && !any_ready) begin
            any_ready = 1'b1;
            sel       = RS_WIDTH'(i);
         end
      end
`endif
   end

   always_comb begin
      any_free = 1'b0;
      alloc    = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!busy[i] && !any_free) begin
            any_free = 1'b1;
            alloc    = RS_WIDTH'(i);
         end
      end
   end

`ifdef RS_AGE_ORDER_EN
   // Ages are kept as the rank among busy entries (0 = youngest).
   // On issue, every older entry steps down by one, so the ages stay
   // compact and can never wrap.
   always_comb begin
      for (int unsigned i = 0; i < RS_SIZE; i++)
         age_nxt[i] = age[i] + RS_WIDTH'(do_alloc)
                      - RS_WIDTH'(do_issue && age[i] > age[sel]);
   end
`endif

   // ALU for the selected entry
   always_comb begin
      logic [31:0]           a, b, im;
      logic [ADDR_WIDTH-1:0] p, seq, im_a;
      logic                  take;
      a       = vj[sel];
      b       = vk[sel];
      im      = imm[sel];
      p       = pc[sel];
      im_a    = ADDR_WIDTH'(im);
      seq     = p + ADDR_WIDTH'(4);
      take    = 1'b0;
      res_val = '0;
      res_pc  = seq;
      case (op[sel])
         OP_LUI:   res_val = im;
         OP_AUIPC: res_val = 32'(p + im_a);
         OP_JAL:   begin res_val = 32'(seq); res_pc = p + im_a; end
         OP_JALR:  begin
            res_val = 32'(seq);
            res_pc  = ADDR_WIDTH'(a + im) & ~ADDR_WIDTH'(1);
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            case (op[sel])
               OP_BEQ:  take = a == b;
               OP_BNE:  take = a != b;
               OP_BLT:  take = $signed(a) <  $signed(b);
               OP_BGE:  take = $signed(a) >= $signed(b);
               OP_BLTU: take = a <  b;
               default: take = a >= b;
            endcase
            res_val = {31'b0, take};
            res_pc  = take ? p + im_a : seq;
         end
         OP_ADDI:  res_val = a + im;
         OP_SLTI:  res_val = {31'b0, $signed(a) < $signed(im)};
         OP_SLTIU: res_val = {31'b0, a < im};
         OP_XORI:  res_val = a ^ im;
         OP_ORI:   res_val = a | im;
         OP_ANDI:  res_val = a & im;
         OP_SLLI:  res_val = a << im[4:0];
         OP_SRLI:  res_val = a >> im[4:0];
         OP_SRAI:  res_val = 32'($signed(a) >>> im[4:0]);
         OP_ADD:   res_val = a + b;
         OP_SUB:   res_val = a - b;
         OP_SLL:   res_val = a << b[4:0];
         OP_SLT:   res_val = {31'b0, $signed(a) < $signed(b)};
         OP_SLTU:  res_val = {31'b0, a < b};
         OP_XOR:   res_val = a ^ b;
         OP_SRL:   res_val = a >> b[4:0];
         OP_SRA:   res_val = 32'($signed(a) >>> b[4:0]);
         OP_OR:    res_val = a | b;
         OP_AND:   res_val = a & b;
         default:  res_val = '0;
      endcase
   end

   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         busy            <= '0;
         RSCDB_en        <= 1'b0;
         RSCDB_RoB_index <= '0;
         RSCDB_value     <= '0;
         RSCDB_next_pc   <= '0;
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            op[i]  <= '0;
            vj[i]  <= '0;
            vk[i]  <= '0;
            qj[i]  <= NON_DEP;
            qk[i]  <= NON_DEP;
            imm[i] <= '0;
            pc[i]  <= '0;
            rob[i] <= '0;
`ifdef RS_AGE_ORDER_EN
            age[i] <= '0;
`endif
         end
      end else if (RoBRS_flush) begin
         busy     <= '0;
         RSCDB_en <= 1'b0;
      end else if (Sys_rdy) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy[i]) begin
               {qj[i], vj[i]} <= snoop(qj[i], vj[i]);
               {qk[i], vk[i]} <= snoop(qk[i], vk[i]);
`ifdef RS_AGE_ORDER_EN
               age[i] <= age_nxt[i];
`endif
            end
         end
         if (slot_free) begin
            if (any_ready) begin
               busy[sel]       <= 1'b0;
               RSCDB_en        <= 1'b1;
               RSCDB_RoB_index <= rob[sel];
               RSCDB_value     <= res_val;
               RSCDB_next_pc   <= res_pc;
            end else begin
               RSCDB_en <= 1'b0;
            end
         end
         if (do_alloc) begin
            busy[alloc]           <= 1'b1;
            op[alloc]             <= DPRS_opcode;
            {qj[alloc], vj[alloc]} <= snoop(DPRS_Qj, DPRS_Vj);
            {qk[alloc], vk[alloc]} <= snoop(DPRS_Qk, DPRS_Vk);
            imm[alloc]            <= DPRS_imm;
            pc[alloc]             <= DPRS_pc;
            rob[alloc]            <= DPRS_RoB_index;
`ifdef RS_AGE_ORDER_EN
            age[alloc]            <= '0;
`endif
         end
      end
   end

endmodule

// File: doc/age_ordered_rs.md
# age_ordered_rs

Parametrised reservation station for the integer/branch execution path. It sits between the dispatcher and the common data bus (CDB), next to the RoB and the LSB. It holds up to 2^RS_WIDTH waiting instructions and snoops NUM_CDB external result buses plus its own result. It issues one ready instruction per cycle, by default the oldest, into a registered result slot that holds its value until the CDB arbiter grants it.

## Interface
- RS_WIDTH, 3: log2 of entry count; RS_SIZE = 1<<RS_WIDTH.
- RoB_WIDTH, 8: RoB index width. Tags are RoB_WIDTH+1 bits; NON_DEP = 1<<RoB_WIDTH.
- ADDR_WIDTH, 32: pc width.
- NUM_CDB, 1: number of external result buses snooped (LSB, future units).
- Sys_clk  in  1  clock, rising edge.
- Sys_rst  in  1  asynchronous, active-high reset.
- Sys_rdy  in  1  global enable; low freezes all state except flush.
- DPRS_en  in  1  dispatch request.
- DPRS_pc  in  ADDR_WIDTH  instruction pc.
- DPRS_Vj, DPRS_Vk  in  32 each  operand values.
- DPRS_Qj, DPRS_Qk  in  RoB_WIDTH+1 each  operand tags; NON_DEP means the value is valid.
- DPRS_imm  in  32  immediate.
- DPRS_opcode  in  7  decoded op code, codebase encoding 1..37; loads/stores are never dispatched here.
- DPRS_RoB_index  in  RoB_WIDTH  destination RoB entry.
- RSDP_full  out  1  all entries busy (combinational from registered busy bits).
- CDBRS_en  in  NUM_CDB  external bus valid bits.
- CDBRS_RoB_index  in  NUM_CDB*RoB_WIDTH  external tags; channel c uses bits [c*RoB_WIDTH +: RoB_WIDTH].
- CDBRS_value  in  NUM_CDB*32  external values, packed the same way.
- CDBRS_grant  in  1  arbiter accepts the current RS result this cycle.
- RSCDB_en  out  1  result slot valid.
- RSCDB_RoB_index  out  RoB_WIDTH  result tag.
- RSCDB_value  out  32  rd value, or branch taken (1/0).
- RSCDB_next_pc  out  ADDR_WIDTH  resolved target for jal/jalr/branches; pc+4 for other ops.
- RoBRS_flush  in  1  mispredict flush, synchronous.

## Operation
- Per entry: busy, opcode, Vj, Vk, Qj, Qk, imm, pc, RoB index, age (RS_WIDTH bits).
- Allocation: when DPRS_en && !RSDP_full, the lowest-index free entry is written with age 0. Every other busy entry's age increments; no saturation is needed because ages stay unique and below RS_SIZE. Dispatch while full is dropped.
- Own broadcast: RSCDB_en && CDBRS_grant, carrying RSCDB_RoB_index and RSCDB_value.
- Wakeup: any busy entry, or an operand being dispatched this cycle, whose Q matches a valid broadcast takes the value and sets Q=NON_DEP. Valid broadcasts are the own broadcast and every external channel. Match priority: own broadcast, then lowest channel.
- Ready: busy && Qj==NON_DEP && Qk==NON_DEP, computed from registered state. A value woken this cycle makes the entry ready next cycle.
- Slot free: !RSCDB_en || CDBRS_grant.
- Issue: if the slot is free and any entry is ready, the selected entry is cleared and its result is registered into the slot. Otherwise a valid slot holds all outputs unchanged. If the slot is granted and nothing is ready, RSCDB_en falls to 0.
- Arithmetic matches the codebase ALU:
  - signed compares and sra/srai use $signed.
  - Shift amounts are bits [4:0].
  - jalr target = (Vj+imm)&~1; jal target = pc+imm.
  - Branches: value = taken; next_pc = taken ? pc+imm : pc+4.
  - lui → imm; auipc → pc+imm; jal/jalr value → pc+4.
  - Unknown opcode → value 0, next_pc pc+4.
- Flush: on a RoBRS_flush edge, all busy bits and RSCDB_en clear, regardless of Sys_rdy. Dispatch and issue in that cycle are discarded.

## Timing
- Reset values: RSCDB_en=0, RSCDB_RoB_index=0, RSCDB_value=0, RSCDB_next_pc=0; all busy=0 and ages=0; RSDP_full=0.
- Minimum latency: an operand-ready dispatch at edge E0 can issue at E1, so RSCDB_en is high after E1.
- Back-to-back issue: a dependent entry woken by the own broadcast at edge E becomes ready after E and issues at E+1.
- A freed entry is reusable one cycle after it issues, because full is derived from registered busy bits.
- Simultaneous dispatch and issue in one cycle are both performed.
- With Sys_rdy low, grant and dispatch are ignored and state holds.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Configuration
- RS_AGE_ORDER_EN defined: the ready entry with the largest age is issued (oldest first).
- RS_AGE_ORDER_EN undefined: age registers and their logic are removed, and the lowest-index ready entry is issued.

## Test plan
- Reset, then dispatch addi (Vj=5, imm=7, RoB 3) → RSCDB_en=1 one cycle later with value 12 and index 3; grant → RSCDB_en=0.
- Dispatch add with Qj=RoB 4; external channel 0 broadcasts tag 4 with value 10; Vk=1 → entry issues the next cycle with value 11. Also cover the same-cycle dispatch-plus-broadcast capture.
- Fill all 8 entries → RSDP_full=1 and a ninth dispatch is ignored. Issue one entry → full drops, and a new dispatch lands in the freed index.
- Hold CDBRS_grant=0 for 3 cycles with 2 ready entries → outputs stay stable; after grant, the second result appears the next cycle.
- With RS_AGE_ORDER_EN: dispatch B into index 1 first, then A into index 0 after the earlier index-0 occupant issues. Make both ready in the same cycle → B issues first. Without the macro → A issues first.
- blt with Vj=-1, Vk=1, pc=0x100, imm=0x20 → value 1, next_pc 0x120. Assert flush while RSCDB_en=1 → RSCDB_en=0 and full=0 the next cycle.
